dlsc_clkrst_seq: RTL and testbench

Parametrised clock/reset sequencer for multi-PLL, multi-domain camera and SERDES front ends. Runs from the free-running reference clock and supervises any number of lock indicators (PLL LOCKED, BUFPLL LOCK). It pulses the PLL reset and releases per-domain reset requests in a fixed order after lock has been stable. On lock loss it re-sequences, with counters for lock losses and timeouts. Each `rst_out` bit feeds that domain's `dlsc_rstsync`.

---
 rtl/dlsc_clkrst_pkg.sv | 32 +++
 rtl/dlsc_clkrst_seq_if.sv | 28 ++
 rtl/dlsc_clkrst_seq_syncflop.sv | 24 ++
 rtl/dlsc_clkrst_seq.sv | 185 ++++++++++++++++++
 tb/tb_dlsc_clkrst_seq.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/dlsc_clkrst_pkg.sv
// Shared types and helpers for the clock/reset sequencer.
// State encoding, counter sizing and saturating increment.
package dlsc_clkrst_pkg;

  typedef enum logic [2:0] {
    ST_PLLRST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN
  } state_t;

  // Width needed to hold (largest cycle count - 1), at least 1 bit.
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dlsc_clkrst_seq_if.sv
// Sequencer bundle: lock inputs, restart, PLL/domain resets, status.
// master = supervising side, slave = sequencer.
interface dlsc_clkrst_seq_if #(
  parameter int LOCKS   = 3,
  parameter int DOMAINS = 3
);

  logic [LOCKS-1:0]   locked_in;
  logic               restart;
  logic               pll_rst;
  logic [DOMAINS-1:0] rst_out;
  logic               ready;
  logic [7:0]         loss_cnt;
  logic [7:0]         timeout_cnt;

  modport master (
    output locked_in, restart,
    input  pll_rst, rst_out, ready,
    input  loss_cnt, timeout_cnt
  );

  modport slave (
    input  locked_in, restart,
    output pll_rst, rst_out, ready,
    output loss_cnt, timeout_cnt
  );

endinterface

// File: rtl/dlsc_clkrst_seq_syncflop.sv
// dlsc_syncflop: 2-flop synchroniser, async active-low reset to 0.
// Ports: clk, rst_n, d[WIDTH] async in, q[WIDTH] synchronised out.
module dlsc_syncflop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/dlsc_clkrst_seq.sv
// PLL reset pulse, lock supervision and ordered domain reset release.
// Ports: clk, rst_n, bus (slave). Option: DLSC_CLKRST_SEQ_RETRY_EN.
module dlsc_clkrst_seq
  import dlsc_clkrst_pkg::*;
#(
  parameter int LOCKS          = 3,
  parameter int DOMAINS        = 3,
  parameter int PLLRST_CYCLES  = 8,
  parameter int STABLE_CYCLES  = 1024,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  dlsc_clkrst_seq_if.slave    bus
);

  localparam int CW = cnt_width(PLLRST_CYCLES, STABLE_CYCLES,
                                GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int IW = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;

  localparam logic [CW-1:0] P_LAST = CW'(PLLRST_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] D_LAST = IW'(DOMAINS - 1);

  logic [LOCKS-1:0] lock_s;
  logic             all_lock;

  dlsc_syncflop #(.WIDTH(LOCKS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.locked_in),
    .q     (lock_s)
  );

  assign all_lock = &lock_s;

  state_t             state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [IW-1:0]      idx, idx_d;
  logic               pll_q, pll_d;
  logic [DOMAINS-1:0] rst_q, rst_d;
  logic               rdy_q, rdy_d;
  logic [7:0]         loss_q, loss_d;
  logic               abort;
  logic               timeout;

`ifdef DLSC_CLKRST_SEQ_RETRY_EN
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tcnt, tcnt_d;
  logic [7:0]    tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    idx_d   = idx;
    pll_d   = pll_q;
    rst_d   = rst_q;
    rdy_d   = rdy_q;
    loss_d  = loss_q;
    abort   = bus.restart;
`ifdef DLSC_CLKRST_SEQ_RETRY_EN
    tcnt_d  = tcnt;
    tmo_d   = tmo_q;
    timeout = (state == ST_WAIT_LOCK || state == ST_STABLE)
              && (tcnt == T_LAST);
    if (state == ST_WAIT_LOCK || state == ST_STABLE)
      tcnt_d = tcnt + CW'(1);
`else
    timeout = 1'b0;
`endif
    unique case (state)
      ST_PLLRST: begin
        if (cnt == P_LAST) begin
          state_d = ST_WAIT_LOCK;
          pll_d   = 1'b0;
          cnt_d   = '0;
`ifdef DLSC_CLKRST_SEQ_RETRY_EN
          tcnt_d  = '0;
`endif
        end
      end
      ST_WAIT_LOCK: begin
        if (timeout) begin
          abort = 1'b1;
        end else if (all_lock) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        // Reaching RELEASE on the limit cycle beats the timeout.
        if (all_lock && cnt == S_LAST) begin
          state_d  = ST_RELEASE;
          idx_d    = '0;
          rst_d[0] = 1'b0;
          cnt_d    = '0;
        end else if (timeout) begin
          abort = 1'b1;
        end else if (!all_lock) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_RELEASE: begin
        if (!all_lock) begin
          abort = 1'b1;
        end else if (cnt == G_LAST) begin
          cnt_d = '0;
          if (idx == D_LAST) begin
            state_d = ST_RUN;
            rdy_d   = 1'b1;
          end else begin
            idx_d        = idx + IW'(1);
            rst_d[idx_d] = 1'b0;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt;
        if (!all_lock) begin
          abort  = 1'b1;
          loss_d = sat_inc(loss_q);
        end
      end
      default: abort = 1'b1;
    endcase
`ifdef DLSC_CLKRST_SEQ_RETRY_EN
    if (timeout && !bus.restart)
      tmo_d = sat_inc(tmo_q);
`endif
    // Every abort path re-asserts all domains at once.
    if (abort) begin
      state_d = ST_PLLRST;
      pll_d   = 1'b1;
      rst_d   = '1;
      rdy_d   = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_PLLRST;
      cnt    <= '0;
      idx    <= '0;
      pll_q  <= 1'b1;
      rst_q  <= '1;
      rdy_q  <= 1'b0;
      loss_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      pll_q  <= pll_d;
      rst_q  <= rst_d;
      rdy_q  <= rdy_d;
      loss_q <= loss_d;
    end
  end

`ifdef DLSC_CLKRST_SEQ_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      tmo_q <= '0;
    end else begin
      tcnt  <= tcnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.timeout_cnt = tmo_q;
`else
  assign bus.timeout_cnt = '0;
`endif

  assign bus.pll_rst  = pll_q;
  assign bus.rst_out  = rst_q;
  assign bus.ready    = rdy_q;
  assign bus.loss_cnt = loss_q;

endmodule

// File: tb/tb_dlsc_clkrst_seq.sv
// Directed bench for dlsc_clkrst_seq: power-up, lock loss,
// glitch, mid-release drop, restart, saturation, timeout.
module tb_dlsc_clkrst_seq;

  localparam int P = 8;
  localparam int S = 32;
  localparam int G = 4;
  localparam int T = 100;

  localparam int W_PLL_LO = 0;
  localparam int W_PLL_HI = 1;
  localparam int W_R0     = 2;
  localparam int W_R1     = 3;
  localparam int W_R2     = 4;
  localparam int W_RDY    = 5;
  localparam int W_ALL1   = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  dlsc_clkrst_seq_if #(.LOCKS(3), .DOMAINS(3)) bus ();

  dlsc_clkrst_seq #(
    .LOCKS          (3),
    .DOMAINS        (3),
    .PLLRST_CYCLES  (P),
    .STABLE_CYCLES  (S),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic logic cond(input int w);
    case (w)
      W_PLL_LO: return bus.pll_rst == 1'b0;
      W_PLL_HI: return bus.pll_rst == 1'b1;
      W_R0:     return bus.rst_out[0] == 1'b0;
      W_R1:     return bus.rst_out[1] == 1'b0;
      W_R2:     return bus.rst_out[2] == 1'b0;
      W_RDY:    return bus.ready == 1'b1;
      W_ALL1:   return bus.rst_out == 3'b111;
      default:  return 1'b1;
    endcase
  endfunction

  // Edges until cond(w) holds; -1 if the budget runs out.
  task automatic wait_for(input int w, input int lim, output int n);
    n = 0;
    while (!cond(w)) begin
      if (n >= lim) begin
        n = -1;
        return;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    @(posedge clk);
    #1;
    bus.restart = 1'b0;
  endtask

  // Domain resets may only ever read 111, 110, 100 or 000.
  always @(negedge clk) begin
    if (rst_n) begin
      check("order",
            {31'd0, bus.rst_out inside {3'b111, 3'b110,
                                        3'b100, 3'b000}},
            32'd1);
    end
  end

  initial begin
    int n;
    bit ok;
    bit rose;
    bus.locked_in = 3'b000;
    bus.restart   = 1'b0;
    #1 rst_n = 1'b0;
    #20;
    check("rst_pll",   bus.pll_rst, 1);
    check("rst_out",   bus.rst_out, 3'b111);
    check("rst_ready", bus.ready, 0);
    check("rst_loss",  bus.loss_cnt, 0);
    check("rst_tmo",   bus.timeout_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    wait_for(W_PLL_LO, 50, n);
    check("pll_pulse", n, P);
    tick(20);
    bus.locked_in = 3'b111;
    wait_for(W_R0, 100, n);
    check("rel0", n, S + 3);
    check("rel0_val", bus.rst_out, 3'b110);
    wait_for(W_R1, 20, n);
    check("rel1", n, G);
    wait_for(W_R2, 20, n);
    check("rel2", n, G);
    wait_for(W_RDY, 20, n);
    check("ready", n, G);
    check("run_out", bus.rst_out, 3'b000);
    check("run_loss", bus.loss_cnt, 0);

    bus.locked_in = 3'b101;
    wait_for(W_ALL1, 10, n);
    check("drop_lat", n, 3);
    check("drop_rdy", bus.ready, 0);
    check("drop_pll", bus.pll_rst, 1);
    check("drop_loss", bus.loss_cnt, 1);
    wait_for(W_PLL_LO, 50, n);
    check("pll_pulse2", n, P);
    tick(5);
    bus.locked_in = 3'b111;
    tick(10);
    bus.locked_in = 3'b000;
    tick(5);
    bus.locked_in = 3'b111;
    wait_for(W_R0, 100, n);
    check("glitch_rel0", n, S + 3);
    wait_for(W_R1, 20, n);
    check("glitch_rel1", n, G);

    bus.locked_in = 3'b000;
    wait_for(W_ALL1, 10, n);
    check("mid_drop", n, 3);
    check("mid_loss", bus.loss_cnt, 1);
    check("mid_rdy", bus.ready, 0);
    wait_for(W_PLL_LO, 50, n);
    check("pll_pulse3", n, P);
    bus.locked_in = 3'b111;
    wait_for(W_RDY, 200, n);
    check("reseq_rdy", n, S + 3 + 3 * G);

    pulse_restart();
    check("rs_out", bus.rst_out, 3'b111);
    check("rs_pll", bus.pll_rst, 1);
    check("rs_rdy", bus.ready, 0);
    check("rs_loss", bus.loss_cnt, 1);
    tick(3);
    pulse_restart();
    wait_for(W_PLL_LO, 50, n);
    check("rs_pulse", n, P);
    wait_for(W_RDY, 200, n);
    check("rs_rdy_lat", n, S + 1 + 3 * G);

    ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.locked_in = 3'b011;
      tick(2);
      pulse_restart();
      if (i == 0) check("both_loss", bus.loss_cnt, 2);
      wait_for(W_PLL_LO, 50, n);
      if (n != P) ok = 1'b0;
      bus.locked_in = 3'b111;
      wait_for(W_RDY, 200, n);
      if (n != S + 3 + 3 * G) ok = 1'b0;
    end
    check("loop_reseq", ok, 1);
    check("loss_sat", bus.loss_cnt, 255);

    bus.locked_in = 3'b000;
    pulse_restart();
    wait_for(W_PLL_LO, 50, n);
    check("tmo_pulse", n, P);
`ifdef DLSC_CLKRST_SEQ_RETRY_EN
    wait_for(W_PLL_HI, 200, n);
    check("tmo_wait1", n, T);
    check("tmo_cnt1", bus.timeout_cnt, 1);
    wait_for(W_PLL_LO, 50, n);
    check("tmo_pulse2", n, P);
    wait_for(W_PLL_HI, 200, n);
    check("tmo_wait2", n, T);
    check("tmo_cnt2", bus.timeout_cnt, 2);
`else
    rose = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (bus.pll_rst) rose = 1'b1;
    end
    check("no_retry", rose, 0);
    check("tmo_zero", bus.timeout_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
